alu_bist: RTL

Synthesizable built-in self-test engine for the single-cycle processor's ALU. It is the hardware counterpart of the ALU test bench: it reads `{f, y_expected}` vectors from a synchronous vector ROM and drives the ALU's `a`, `b` and `f` inputs. It compares the ALU's `y` against the expected value, counts mismatches, and records the first failure. It sits beside the datapath ALU, muxed onto the ALU inputs while `busy` is high.

---
 rtl/alu_bist.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_bist.sv
// Built-in self-test engine for the ALU: replays {f, y_expected} vectors from a
// synchronous ROM against latched operands and records mismatches.
module alu_bist #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic [ADDR_W:0]   vec_count,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [34:0]       vec_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_f,
    input  logic [31:0]       alu_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_num,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [31:0]       first_err_y,
    output logic [31:0]       first_err_exp
);

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, CHECK, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_VEC = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nx;
    logic [31:0]     a_q, b_q, exp_q;
    logic [2:0]      f_q;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] vec_num_nx;
    logic            accept;
    logic            mismatch;

    assign accept     = start && (state == IDLE || state == DONE);
    assign mismatch   = (state == CHECK) && (alu_y != exp_q);
    assign vec_num_nx = vec_num + 1'b1;

    // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = (vec_count == '0) ? DONE : FETCH;
            FETCH:      state_nx = APPLY;
            APPLY:      state_nx = CHECK;
            CHECK:      state_nx = (vec_num_nx == count_q) ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    // NOTE: all registers here use non-blocking assignment so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            count_q       <= '0;
            f_q           <= '0;
            exp_q         <= '0;
            err_count     <= '0;
            vec_num       <= '0;
            first_err_idx <= '0;
            first_err_y   <= '0;
            first_err_exp <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q           <= op_a;
                b_q           <= op_b;
                count_q       <= (vec_count > MAX_VEC) ? MAX_VEC : vec_count;
                err_count     <= '0;
                vec_num       <= '0;
                first_err_idx <= '0;
                first_err_y   <= '0;
                first_err_exp <= '0;
            end
            if (state == APPLY) begin
                f_q   <= vec_data[34:32];
                exp_q <= vec_data[31:0];
            end
            if (state == CHECK) begin
                vec_num <= vec_num_nx;
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    // A zero count means no failure has been captured yet this run.
                    if (err_count == '0) begin
                        first_err_idx <= vec_num[ADDR_W-1:0];
                        first_err_y   <= alu_y;
                        first_err_exp <= exp_q;
                    end
                end
            end
        end
    end

    assign busy     = (state == FETCH) || (state == APPLY) || (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);
    assign vec_rd   = (state == FETCH);
    assign vec_addr = vec_rd ? vec_num[ADDR_W-1:0] : '0;
    assign alu_a    = busy ? a_q : '0;
    assign alu_b    = busy ? b_q : '0;
    assign alu_f    = (state == APPLY || state == CHECK) ? f_q : '0;

endmodule
